// File: rtl/bmc_soft_pipe.sv
// Pipelined branch-metric unit: per-symbol soft/hard distances with erasures,
// metrics for every code-word hypothesis plus lowest-index minimum, two register stages.
`timescale 1ns/1ps
module bmc_soft_pipe #(
    parameter  int SOFT_W = 3,
    parameter  int N_OUT  = 2,
    localparam int NH     = 1 << N_OUT,
    localparam int BM_W   = SOFT_W + $clog2(N_OUT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_OUT*SOFT_W-1:0] rx_sym,
    input  logic [N_OUT-1:0]        rx_erase,
    input  logic                    hard_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NH*BM_W-1:0]      bm,
    output logic [BM_W-1:0]         bm_min,
    output logic [N_OUT-1:0]        bm_min_idx,
    output logic [15:0]             step_cnt
);

    localparam logic [SOFT_W-1:0] MAX = '1;

    logic                    s1_valid_q;
    logic [N_OUT*SOFT_W-1:0] sym_q;
    logic [N_OUT-1:0]        erase_q;
    logic                    hard_q;

    logic                    out_valid_q;
    logic [NH-1:0][BM_W-1:0] bm_q;
    logic [BM_W-1:0]         min_q;
    logic [N_OUT-1:0]        idx_q;
    logic [15:0]             cnt_q;

    logic adv1, adv2;
    logic [N_OUT-1:0][SOFT_W-1:0] dist0, dist1;
    logic [NH-1:0][BM_W-1:0]      bm_d;
    logic [BM_W-1:0]              min_d;
    logic [N_OUT-1:0]             idx_d;

    assign adv2     = !out_valid_q | out_ready;
    assign adv1     = !s1_valid_q | adv2;
    assign in_ready = adv1;

    // Distances to expected bit 0 / bit 1 for each captured symbol.
    always_comb begin
        dist0 = '0;
        dist1 = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (erase_q[i]) begin
                dist0[i] = '0;
                dist1[i] = '0;
            end else if (hard_q) begin
                dist0[i] = SOFT_W'(sym_q[i*SOFT_W + SOFT_W-1]);
                dist1[i] = SOFT_W'(!sym_q[i*SOFT_W + SOFT_W-1]);
            end else begin
                dist0[i] = sym_q[i*SOFT_W +: SOFT_W];
                dist1[i] = MAX - sym_q[i*SOFT_W +: SOFT_W];
            end
        end
    end

    // Hypothesis metrics and strict-less-than scan so ties keep the lowest index.
    always_comb begin
        bm_d  = '0;
        min_d = '0;
        idx_d = '0;
        for (int h = 0; h < NH; h++) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (((h >> i) & 1) != 0)
                    bm_d[h] = bm_d[h] + BM_W'(dist1[i]);
                else
                    bm_d[h] = bm_d[h] + BM_W'(dist0[i]);
            end
        end
        min_d = bm_d[0];
        for (int h = 1; h < NH; h++) begin
            if (bm_d[h] < min_d) begin
                min_d = bm_d[h];
                idx_d = N_OUT'(h);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            sym_q      <= '0;
            erase_q    <= '0;
            hard_q     <= 1'b0;
        end else if (adv1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                sym_q   <= rx_sym;
                erase_q <= rx_erase;
                hard_q  <= hard_mode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            bm_q        <= '0;
            min_q       <= '0;
            idx_q       <= '0;
        end else if (adv2) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                bm_q  <= bm_d;
                min_q <= min_d;
                idx_q <= idx_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (out_valid_q && out_ready)
            cnt_q <= cnt_q + 16'd1;
    end

    assign out_valid  = out_valid_q;
    assign bm         = bm_q;
    assign bm_min     = min_q;
    assign bm_min_idx = idx_q;
    assign step_cnt   = cnt_q;

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Directed bench for bmc_soft_pipe at SOFT_W=3, N_OUT=2 (BM_W=4, four hypotheses).
`timescale 1ns/1ps
module tb_bmc_soft_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  rx_sym;
    logic [1:0]  rx_erase;
    logic        hard_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] bm;
    logic [3:0]  bm_min;
    logic [1:0]  bm_min_idx;
    logic [15:0] step_cnt;

    int checks = 0;
    int errors = 0;

    bmc_soft_pipe #(.SOFT_W(3), .N_OUT(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rx_sym     (rx_sym),
        .rx_erase   (rx_erase),
        .hard_mode  (hard_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .bm         (bm),
        .bm_min     (bm_min),
        .bm_min_idx (bm_min_idx),
        .step_cnt   (step_cnt)
    );

    always #5 clk = ~clk;

    // Stimulus only: present one step, return at cycle t+2 (posedge+1).
    task automatic drive_step(input logic [5:0] sym, input logic [1:0] er,
                              input logic hd, output logic ov_mid);
        in_valid  = 1'b1;
        rx_sym    = sym;
        rx_erase  = er;
        hard_mode = hd;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ov_mid   = out_valid;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        checks++; if (bm !== 16'h0000) begin errors++; $display("FAIL rst_bm got %h exp 0000", bm); end
        checks++; if (bm_min !== 4'd0 || bm_min_idx !== 2'd0) begin errors++; $display("FAIL rst_min got %0d/%0d exp 0/0", bm_min, bm_min_idx); end
        checks++; if (step_cnt !== 16'd0) begin errors++; $display("FAIL rst_step_cnt got %0d exp 0", step_cnt); end
        #20;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // sym0=7, sym1=0 soft: bm = {7,0,14,7}
    task automatic test_soft();
        logic ov_mid;
        drive_step(6'b000_111, 2'b00, 1'b0, ov_mid);
        checks++; if (ov_mid !== 1'b0) begin errors++; $display("FAIL soft_latency out_valid at t+1 got %b exp 0", ov_mid); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL soft_valid got %b exp 1", out_valid); end
        checks++; if (bm !== 16'h7E07) begin errors++; $display("FAIL soft_bm got %h exp 7e07", bm); end
        checks++; if (bm_min !== 4'd0 || bm_min_idx !== 2'd1) begin errors++; $display("FAIL soft_min got %0d/%0d exp 0/1", bm_min, bm_min_idx); end
        @(posedge clk); #1;
        checks++; if (step_cnt !== 16'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL soft_cnt got %0d/%b exp 1/0", step_cnt, out_valid); end
    endtask

    // Hard bits (1,0): bm = {1,0,2,1}
    task automatic test_hard();
        logic ov_mid;
        drive_step(6'b000_111, 2'b00, 1'b1, ov_mid);
        checks++; if (out_valid !== 1'b1 || bm !== 16'h1201) begin errors++; $display("FAIL hard_bm got %b/%h exp 1/1201", out_valid, bm); end
        checks++; if (bm_min !== 4'd0 || bm_min_idx !== 2'd1) begin errors++; $display("FAIL hard_min got %0d/%0d exp 0/1", bm_min, bm_min_idx); end
        @(posedge clk); #1;
        checks++; if (step_cnt !== 16'd2) begin errors++; $display("FAIL hard_cnt got %0d exp 2", step_cnt); end
    endtask

    // Hard bits (1,1): bm = {2,1,1,0}, min at h=3
    task automatic test_hard_ones();
        logic ov_mid;
        drive_step(6'b111_111, 2'b00, 1'b1, ov_mid);
        checks++; if (bm !== 16'h0112) begin errors++; $display("FAIL hard11_bm got %h exp 0112", bm); end
        checks++; if (bm_min !== 4'd0 || bm_min_idx !== 2'd3) begin errors++; $display("FAIL hard11_min got %0d/%0d exp 0/3", bm_min, bm_min_idx); end
        @(posedge clk); #1;
        checks++; if (step_cnt !== 16'd3) begin errors++; $display("FAIL hard11_cnt got %0d exp 3", step_cnt); end
    endtask

    // Symbol 0 erased: bm = {0,0,7,7}, tie goes to h=0
    task automatic test_erase();
        logic ov_mid;
        drive_step(6'b000_111, 2'b01, 1'b0, ov_mid);
        checks++; if (bm !== 16'h7700) begin errors++; $display("FAIL erase_bm got %h exp 7700", bm); end
        checks++; if (bm_min !== 4'd0 || bm_min_idx !== 2'd0) begin errors++; $display("FAIL erase_min got %0d/%0d exp 0/0", bm_min, bm_min_idx); end
        @(posedge clk); #1;
        checks++; if (step_cnt !== 16'd4) begin errors++; $display("FAIL erase_cnt got %0d exp 4", step_cnt); end
    endtask

    // Step k: sym0=k%8, sym1=k/8 soft; bm[0]=k%8+k/8, bm[1]=7-k%8+k/8.
    task automatic test_back_to_back();
        int sent = 0;
        int recv = 0;
        logic stall_prev = 1'b0;
        logic saw_block  = 1'b0;
        logic [15:0] bm_prev = '0;
        int e0, e1;
        for (int c = 0; c < 60 && recv < 10; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            if (sent < 10) begin
                in_valid  = 1'b1;
                rx_sym    = {3'(sent / 8), 3'(sent % 8)};
                rx_erase  = 2'b00;
                hard_mode = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #3;
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || bm !== bm_prev) begin errors++; $display("FAIL stall_hold cycle %0d got %b/%h exp 1/%h", c, out_valid, bm, bm_prev); end
            end
            if (!in_ready) saw_block = 1'b1;
            if (out_valid && out_ready) begin
                e0 = recv % 8 + recv / 8;
                e1 = 7 - recv % 8 + recv / 8;
                checks++;
                if (bm[3:0] !== 4'(e0) || bm[7:4] !== 4'(e1)) begin errors++; $display("FAIL b2b_step %0d got %0d/%0d exp %0d/%0d", recv, bm[3:0], bm[7:4], e0, e1); end
                recv++;
            end
            if (in_valid && in_ready) sent++;
            stall_prev = out_valid && !out_ready;
            bm_prev    = bm;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++; if (recv != 10) begin errors++; $display("FAIL b2b_count got %0d exp 10", recv); end
        checks++; if (saw_block !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_drop got %b exp 1", saw_block); end
        checks++; if (step_cnt !== 16'd14) begin errors++; $display("FAIL b2b_cnt got %0d exp 14", step_cnt); end
    endtask

    task automatic test_midreset();
        logic ov_mid;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rx_sym    = 6'b010_011;
        rx_erase  = 2'b00;
        hard_mode = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL full_pipe got ready %b valid %b exp 0/1", in_ready, out_valid); end
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || step_cnt !== 16'd0) begin errors++; $display("FAIL midrst_clear got %b/%0d exp 0/0", out_valid, step_cnt); end
        checks++; if (in_ready !== 1'b1 || bm !== 16'h0000) begin errors++; $display("FAIL midrst_state got %b/%h exp 1/0000", in_ready, bm); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        drive_step(6'b000_111, 2'b00, 1'b0, ov_mid);
        checks++; if (ov_mid !== 1'b0) begin errors++; $display("FAIL midrst_flushed got %b exp 0", ov_mid); end
        checks++; if (out_valid !== 1'b1 || bm !== 16'h7E07 || step_cnt !== 16'd0) begin errors++; $display("FAIL midrst_step got %b/%h/%0d exp 1/7e07/0", out_valid, bm, step_cnt); end
        @(posedge clk); #1;
        checks++; if (step_cnt !== 16'd1) begin errors++; $display("FAIL midrst_cnt got %0d exp 1", step_cnt); end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rx_sym    = '0;
        rx_erase  = '0;
        hard_mode = 1'b0;
        test_reset();
        test_soft();
        test_hard();
        test_hard_ones();
        test_erase();
        test_back_to_back();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
